// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// values, the one-hot ALU operation codes and every datapath select encoding.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_R_EXEC,
    ST_R_WB,
    ST_I_EXEC,
    ST_I_WB,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_BRANCH,
    ST_JUMP,
    ST_JR
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // One-hot operation codes, shared with the ALU.
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_OR   = 5'b10000;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RT    = 2'b00;
  localparam logic [1:0] REG_DST_RD    = 2'b01;
  localparam logic [1:0] REG_DST_RA    = 2'b10;

  localparam logic [1:0] M2R_ALUOUT    = 2'b00;
  localparam logic [1:0] M2R_MDR       = 2'b01;
  localparam logic [1:0] M2R_PC        = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_alu_op_decode.sv
// Maps R-type funct or I-type opcode to the one-hot ALU operation.
// valid is low for anything the execute states do not recognise (alu_op stays ADD).
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin alu_op = ALU_ADD; valid = 1'b1; end
          FN_SUB:  begin alu_op = ALU_SUB; valid = 1'b1; end
          FN_AND:  begin alu_op = ALU_AND; valid = 1'b1; end
          FN_OR:   begin alu_op = ALU_OR;  valid = 1'b1; end
          FN_SLT:  begin alu_op = ALU_SLT; valid = 1'b1; end
          default: begin alu_op = ALU_ADD; valid = 1'b0; end
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; valid = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; valid = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; valid = 1'b1; end
      default: begin alu_op = ALU_ADD; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the one-hot alu_op plus every datapath select and enable (Moore outputs).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [4:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg
);

  state_e     state;
  state_e     state_nxt;
  logic [4:0] dec_alu_op;
  logic       dec_valid;

  alu_op_decode u_alu_op_decode (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET_IDLE;
    else        state <= state_nxt;
  end

  // Memory handshake: the FSM holds mem_read/mem_write (and the address select)
  // steady in FETCH, MEM_READ and MEM_WRITE; the access completes in the cycle
  // mem_ready is high, and only then does the state advance.
  always_comb begin
    state_nxt = ST_RESET_IDLE;
    case (state)
      ST_RESET_IDLE: state_nxt = ST_FETCH;
      ST_FETCH:      state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:               state_nxt = (funct == FN_JR) ? ST_JR : ST_R_EXEC;
          OP_LW, OP_SW:           state_nxt = ST_MEM_ADDR;
          OP_ADDI, OP_SLTI,
          OP_ANDI:                state_nxt = ST_I_EXEC;
          OP_BEQ, OP_BNE:         state_nxt = ST_BRANCH;
          OP_J, OP_JAL:           state_nxt = ST_JUMP;
          default:                state_nxt = ST_FETCH;
        endcase
      end
      ST_R_EXEC:     state_nxt = dec_valid ? ST_R_WB : ST_FETCH;
      ST_R_WB:       state_nxt = ST_FETCH;
      ST_I_EXEC:     state_nxt = ST_I_WB;
      ST_I_WB:       state_nxt = ST_FETCH;
      ST_MEM_ADDR:   state_nxt = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:   state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:     state_nxt = ST_FETCH;
      ST_MEM_WRITE:  state_nxt = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_BRANCH:     state_nxt = ST_FETCH;
      ST_JUMP:       state_nxt = ST_FETCH;
      ST_JR:         state_nxt = ST_FETCH;
      default:       state_nxt = ST_RESET_IDLE;
    endcase
  end

  // Outputs decode from the registered state, so an async reset clears every
  // enable in the same instant the state register clears.
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      ST_DECODE: alu_src_b = SRC_B_IMM_SH2;
      ST_R_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_op    = dec_alu_op;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REG_DST_RD;
      end
      ST_I_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = dec_alu_op;
      end
      ST_I_WB:   reg_write = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
      end
      ST_JUMP: begin
        pc_en  = 1'b1;
        pc_src = PC_SRC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      ST_JR: begin
        pc_en  = 1'b1;
        pc_src = PC_SRC_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, hand-written corner sequences and
// random instructions scored against an instruction-level reference model.
module tb_mc_ctrl_fsm;

  localparam logic [4:0] A_ADD = 5'b00001;
  localparam logic [4:0] A_SUB = 5'b00010;
  localparam logic [4:0] A_AND = 5'b00100;
  localparam logic [4:0] A_SLT = 5'b01000;
  localparam logic [4:0] A_OR  = 5'b10000;

  localparam logic [5:0] O_R = 6'h00, O_J = 6'h02, O_JAL = 6'h03, O_BEQ = 6'h04;
  localparam logic [5:0] O_BNE = 6'h05, O_ADDI = 6'h08, O_SLTI = 6'h0a, O_ANDI = 6'h0c;
  localparam logic [5:0] O_LW = 6'h23, O_SW = 6'h2b, O_BAD = 6'h3f;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2a, F_BAD = 6'h3f;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [4:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg)
  );

  // ---------------- scoreboard types ----------------
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         mw;
    int         cyc;
    int         regw;
    int         pcen;
    int         memw;
    logic [4:0] aop;
    bit         chk_op;
  } vec_t;

  typedef struct {
    logic [4:0] alu_op;
    logic       src_a;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
  } smp_t;

  int         checks = 0;
  int         errors = 0;
  smp_t       trace[$];
  int         o_cyc, o_regw, o_pcen, o_memw, o_irw, o_ovl, o_badhot;
  logic [4:0] o_lastop;
  vec_t       vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: cycle count, write/enable counts, execute op.
  function automatic vec_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fw, input int mw);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.fw = fw; v.mw = mw;
    v.cyc = fw; v.regw = 0; v.pcen = 1; v.memw = 0; v.aop = A_ADD; v.chk_op = 1'b0;
    case (op)
      O_R: begin
        if (fn == F_JR) begin v.cyc += 3; v.pcen = 2; end
        else begin
          v.cyc += 3;
          v.chk_op = 1'b1;
          case (fn)
            F_ADD: v.aop = A_ADD;
            F_SUB: v.aop = A_SUB;
            F_AND: v.aop = A_AND;
            F_OR:  v.aop = A_OR;
            F_SLT: v.aop = A_SLT;
            default: v.chk_op = 1'b0;
          endcase
          if (v.chk_op) begin v.cyc += 1; v.regw = 1; end
        end
      end
      O_LW:   begin v.cyc += 5 + mw; v.regw = 1; v.chk_op = 1'b1; end
      O_SW:   begin v.cyc += 4 + mw; v.memw = 1 + mw; v.chk_op = 1'b1; end
      O_ADDI: begin v.cyc += 4; v.regw = 1; v.aop = A_ADD; v.chk_op = 1'b1; end
      O_SLTI: begin v.cyc += 4; v.regw = 1; v.aop = A_SLT; v.chk_op = 1'b1; end
      O_ANDI: begin v.cyc += 4; v.regw = 1; v.aop = A_AND; v.chk_op = 1'b1; end
      O_BEQ:  begin v.cyc += 3; v.pcen += z ? 1 : 0;  v.aop = A_SUB; v.chk_op = 1'b1; end
      O_BNE:  begin v.cyc += 3; v.pcen += z ? 0 : 1;  v.aop = A_SUB; v.chk_op = 1'b1; end
      O_J:    begin v.cyc += 3; v.pcen = 2; end
      O_JAL:  begin v.cyc += 3; v.pcen = 2; v.regw = 1; end
      default: v.cyc += 2;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Starts at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int  fw_left, mw_left;
    bit  prev_fetch, is_fetch, done;
    smp_t s;
    trace.delete();
    o_cyc = 0; o_regw = 0; o_pcen = 0; o_memw = 0; o_irw = 0; o_ovl = 0; o_badhot = 0;
    o_lastop = 5'b0;
    fw_left = fw; mw_left = mw; prev_fetch = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      is_fetch = mem_read && !i_or_d;
      if (k > 0 && is_fetch && !prev_fetch) done = 1'b1;
      else begin
        opcode = op; funct = fn; zero = z;
        if (is_fetch) begin
          if (fw_left > 0) begin mem_ready = 1'b0; fw_left--; end
          else mem_ready = 1'b1;
        end else if (mem_read || mem_write) begin
          if (mw_left > 0) begin mem_ready = 1'b0; mw_left--; end
          else mem_ready = 1'b1;
        end else mem_ready = 1'($urandom_range(0, 1));
        #2;
        s.alu_op = alu_op; s.src_a = alu_src_a; s.pc_src = pc_src; s.pc_en = pc_en;
        s.i_or_d = i_or_d; s.mem_read = mem_read; s.mem_write = mem_write;
        s.reg_write = reg_write; s.reg_dst = reg_dst; s.mem_to_reg = mem_to_reg;
        trace.push_back(s);
        o_cyc++;
        o_regw += int'(reg_write);
        o_pcen += int'(pc_en);
        o_memw += int'(mem_write);
        o_irw  += int'(ir_write);
        o_ovl  += int'(pc_en && reg_write);
        if (!$onehot(alu_op)) o_badhot++;
        if (alu_src_a) o_lastop = alu_op;
        prev_fetch = is_fetch;
        @(posedge clk); #1;
      end
    end
    check("instr_completes", 32'(done), 32'd1);
  endtask

  task automatic apply(input vec_t v, input string tag);
    run_instr(v.op, v.fn, v.z, v.fw, v.mw);
    check({tag, "_cycles"}, o_cyc, v.cyc);
    check({tag, "_reg_write"}, o_regw, v.regw);
    check({tag, "_pc_en"}, o_pcen, v.pcen);
    check({tag, "_mem_write"}, o_memw, v.memw);
    check({tag, "_ir_write"}, o_irw, 1);
    check({tag, "_pc_reg_overlap"}, o_ovl, (v.op == O_JAL) ? 1 : 0);
    check({tag, "_onehot"}, o_badhot, 0);
    if (v.chk_op) check({tag, "_exec_op"}, o_lastop, v.aop);
  endtask

  task automatic check_all_off(input string tag);
    check({tag, "_enables"}, {pc_en, ir_write, reg_write, mem_read, mem_write}, 5'b0);
    check({tag, "_alu_op"}, alu_op, A_ADD);
    check({tag, "_selects"}, {alu_src_a, alu_src_b, pc_src, i_or_d, reg_dst, mem_to_reg}, 10'b0);
  endtask

  // Releases reset just after a posedge: one RESET_IDLE cycle, then FETCH.
  task automatic release_reset(input string tag);
    rst_n = 1'b1; mem_ready = 1'b1;
    #2 check_all_off({tag, "_idle"});
    @(posedge clk); #1;
    check({tag, "_first_fetch"}, {mem_read, i_or_d}, 2'b10);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_pool [12];
  logic [5:0] fn_pool [7];

  initial begin
    op_pool = '{O_R, O_R, O_LW, O_SW, O_ADDI, O_SLTI, O_ANDI, O_BEQ, O_BNE, O_J, O_JAL, O_BAD};
    fn_pool = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR, F_BAD};

    // op, fn, z, fw, mw, cycles, regw, pcen, memw, exec op, check op
    vecs.push_back('{O_R,    F_ADD, 0, 0, 0, 4, 1, 1, 0, A_ADD, 1});
    vecs.push_back('{O_R,    F_SUB, 0, 1, 0, 5, 1, 1, 0, A_SUB, 1});
    vecs.push_back('{O_R,    F_AND, 1, 0, 0, 4, 1, 1, 0, A_AND, 1});
    vecs.push_back('{O_R,    F_OR,  0, 0, 0, 4, 1, 1, 0, A_OR,  1});
    vecs.push_back('{O_R,    F_SLT, 0, 0, 0, 4, 1, 1, 0, A_SLT, 1});
    vecs.push_back('{O_R,    F_JR,  0, 0, 0, 3, 0, 2, 0, A_ADD, 0});
    vecs.push_back('{O_R,    F_BAD, 0, 0, 0, 3, 0, 1, 0, A_ADD, 0});
    vecs.push_back('{O_LW,   F_BAD, 0, 0, 1, 6, 1, 1, 0, A_ADD, 1});
    vecs.push_back('{O_SW,   F_BAD, 0, 0, 2, 6, 0, 1, 3, A_ADD, 1});
    vecs.push_back('{O_ADDI, F_BAD, 0, 0, 0, 4, 1, 1, 0, A_ADD, 1});
    vecs.push_back('{O_SLTI, F_ADD, 0, 2, 0, 6, 1, 1, 0, A_SLT, 1});
    vecs.push_back('{O_ANDI, F_ADD, 0, 0, 0, 4, 1, 1, 0, A_AND, 1});
    vecs.push_back('{O_BEQ,  F_ADD, 0, 0, 0, 3, 0, 1, 0, A_SUB, 1});
    vecs.push_back('{O_BNE,  F_ADD, 0, 0, 0, 3, 0, 2, 0, A_SUB, 1});
    vecs.push_back('{O_J,    F_ADD, 0, 0, 0, 3, 0, 2, 0, A_ADD, 0});
    vecs.push_back('{O_JAL,  F_ADD, 0, 0, 0, 3, 1, 2, 0, A_ADD, 0});
    vecs.push_back('{O_BAD,  F_ADD, 0, 0, 0, 2, 0, 1, 0, A_ADD, 0});

    // Reset held 3 cycles with mem_ready high: nothing may strobe.
    rst_n = 1'b0; opcode = O_R; funct = F_ADD; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check_all_off("reset_hold");
    end
    @(posedge clk); #1;
    release_reset("reset");

    // Directed table.
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // R-type sub: SUB in R_EXEC, rd write in the 4th cycle.
    run_instr(O_R, F_SUB, 1'b0, 0, 0);
    check("sub_cycles", o_cyc, 4);
    if (trace.size() >= 4) begin
      check("sub_exec_alu_op", trace[2].alu_op, A_SUB);
      check("sub_wb", {trace[3].reg_write, trace[3].reg_dst}, 3'b101);
    end

    // lw with two wait cycles in MEM_READ.
    run_instr(O_LW, F_ADD, 1'b0, 0, 2);
    check("lw_cycles", o_cyc, 7);
    if (trace.size() >= 7) begin
      for (int i = 3; i < 6; i++)
        check($sformatf("lw_mem_read_c%0d", i), {trace[i].mem_read, trace[i].i_or_d}, 2'b11);
      check("lw_wb", {trace[6].reg_write, trace[6].mem_to_reg, trace[6].reg_dst}, 5'b10100);
    end

    // beq taken vs bne not taken, both with zero=1.
    run_instr(O_BEQ, F_ADD, 1'b1, 0, 0);
    check("beq_cycles", o_cyc, 3);
    if (trace.size() >= 3) check("beq_branch", {trace[2].pc_en, trace[2].pc_src}, 3'b101);
    run_instr(O_BNE, F_ADD, 1'b1, 0, 0);
    check("bne_cycles", o_cyc, 3);
    if (trace.size() >= 3) check("bne_branch", {trace[2].pc_en, trace[2].pc_src}, 3'b001);

    // jal link write alongside the jump.
    run_instr(O_JAL, F_ADD, 1'b0, 0, 0);
    if (trace.size() >= 3)
      check("jal_jump", {trace[2].pc_en, trace[2].pc_src, trace[2].reg_write,
                         trace[2].reg_dst, trace[2].mem_to_reg}, 8'b1_10_1_10_10);

    // Unknown opcode falls straight back to FETCH.
    run_instr(O_BAD, F_ADD, 1'b0, 0, 0);
    check("nop_cycles", o_cyc, 2);
    check("nop_writes", o_regw + o_memw, 0);

    // Reset pulsed in the middle of a MEM_WRITE wait.
    opcode = O_SW; funct = F_ADD; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    check("sw_wait_mem_write", {mem_write, i_or_d}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_all_off("reset_async");
    repeat (2) @(posedge clk);
    #1 release_reset("restart");
    apply(model(O_R, F_OR, 1'b0, 0, 0), "restart_or");

    // Random instructions against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      op = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = fn_pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
      apply(model(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 3)), $sformatf("rnd%0d_op%0h_fn%0h", n, op, fn));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
